// File: rtl/event_kernel_scheduler_if.sv
// Bundle of the request, kernel (ap_ctrl_hs) and response channels of the
// event kernel scheduler. The master modport is the scheduler's view; the
// slave modport is the view of the LP front-ends plus kernel side.
interface event_kernel_scheduler_if #(
  parameter int N_REQ  = 4,
  parameter int TS_W   = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 2
);
  // Requester side
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        req_rollback;
  logic [N_REQ*TS_W-1:0]   req_ts;
  logic [N_REQ*DATA_W-1:0] req_data;

  // Kernel side
  logic                    k_ap_start;
  logic                    k_ap_ready;
  logic                    k_ap_done;
  logic                    k_rollback;
  logic [TS_W-1:0]         k_ts;
  logic [DATA_W-1:0]       k_data;
  logic [DATA_W-1:0]       k_return;

  // Response side
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [DATA_W-1:0]       rsp_data;

  modport master (
    input  req_valid, req_rollback, req_ts, req_data,
    input  k_ap_ready, k_ap_done, k_return,
    input  rsp_ready,
    output req_ready,
    output k_ap_start, k_rollback, k_ts, k_data,
    output rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    output req_valid, req_rollback, req_ts, req_data,
    output k_ap_ready, k_ap_done, k_return,
    output rsp_ready,
    input  req_ready,
    input  k_ap_start, k_rollback, k_ts, k_data,
    input  rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/event_kernel_scheduler.sv
// Event kernel scheduler: shares one ap_ctrl_hs event_history_kernel among
// N_REQ logical-process requesters. Rollback commands win over inserts and
// each class is served round-robin with its own pointer. Only one kernel
// invocation is ever outstanding.
// Optional feature: define SCHED_PERF_CNT_EN to add saturating 32-bit
// performance counters (busy cycles, grants per class, response stalls).
module event_kernel_scheduler #(
  parameter int N_REQ  = 4,
  parameter int TS_W   = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 2
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  event_kernel_scheduler_if.master bus,
  output logic busy,
  output logic err_spurious_done
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0] cnt_busy,
  output logic [31:0] cnt_grant_ev,
  output logic [31:0] cnt_grant_rb,
  output logic [31:0] cnt_stall_rsp
`endif
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, RESPOND} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rbPtr_q, rbPtr_d;
  logic [ID_W-1:0]     evPtr_q, evPtr_d;
  logic                kRollback_q, kRollback_d;
  logic [TS_W-1:0]     kTs_q, kTs_d;
  logic [DATA_W-1:0]   kData_q, kData_d;
  logic [ID_W-1:0]     rspId_q, rspId_d;
  logic [DATA_W-1:0]   rspData_q, rspData_d;
  logic                errSpurious_q, errSpurious_d;

  logic [N_REQ-1:0]    rbMask, evMask;
  logic                rbFound, evFound;
  logic [ID_W-1:0]     rbIdx, evIdx;
  logic                grantValid, grantRb;
  logic [ID_W-1:0]     winner, winnerNext;

  // Winner selection: first candidate at or after each class pointer, scanned
  // from the far end so the nearest hit overwrites the others.
  always_comb begin
    rbMask  = bus.req_valid & bus.req_rollback;
    evMask  = bus.req_valid & ~bus.req_rollback;
    rbFound = 1'b0;
    rbIdx   = '0;
    evFound = 1'b0;
    evIdx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rbMask[ID_W'((int'(rbPtr_q) + k) % N_REQ)]) begin
        rbFound = 1'b1;
        rbIdx   = ID_W'((int'(rbPtr_q) + k) % N_REQ);
      end
      if (evMask[ID_W'((int'(evPtr_q) + k) % N_REQ)]) begin
        evFound = 1'b1;
        evIdx   = ID_W'((int'(evPtr_q) + k) % N_REQ);
      end
    end
    grantValid = rbFound | evFound;
    grantRb    = rbFound;
    winner     = rbFound ? rbIdx : evIdx;
    winnerNext = (int'(winner) == N_REQ - 1) ? '0 : winner + ID_W'(1);
  end

  // State and datapath registers; reset kills any launch or response in flight.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q       <= IDLE;
      rbPtr_q       <= '0;
      evPtr_q       <= '0;
      kRollback_q   <= 1'b0;
      kTs_q         <= '0;
      kData_q       <= '0;
      rspId_q       <= '0;
      rspData_q     <= '0;
      errSpurious_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rbPtr_q       <= rbPtr_d;
      evPtr_q       <= evPtr_d;
      kRollback_q   <= kRollback_d;
      kTs_q         <= kTs_d;
      kData_q       <= kData_d;
      rspId_q       <= rspId_d;
      rspData_q     <= rspData_d;
      errSpurious_q <= errSpurious_d;
    end
  end

  // Next-state logic: grant and latch operands in IDLE, follow the kernel
  // handshake, hold the response until it is accepted.
  always_comb begin
    state_d       = state_q;
    rbPtr_d       = rbPtr_q;
    evPtr_d       = evPtr_q;
    kRollback_d   = kRollback_q;
    kTs_d         = kTs_q;
    kData_d       = kData_q;
    rspId_d       = rspId_q;
    rspData_d     = rspData_q;
    errSpurious_d = errSpurious_q;

    case (state_q)
      IDLE: begin
        if (grantValid) begin
          kRollback_d = grantRb;
          kTs_d       = bus.req_ts[int'(winner)*TS_W +: TS_W];
          kData_d     = bus.req_data[int'(winner)*DATA_W +: DATA_W];
          rspId_d     = winner;
          if (grantRb) begin
            rbPtr_d = winnerNext;
          end else begin
            evPtr_d = winnerNext;
          end
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (bus.k_ap_ready) begin
          if (bus.k_ap_done) begin
            rspData_d = bus.k_return;
            state_d   = RESPOND;
          end else begin
            state_d = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (bus.k_ap_done) begin
          rspData_d = bus.k_return;
          state_d   = RESPOND;
        end
      end
      RESPOND: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.k_ap_done && (state_q == IDLE || state_q == RESPOND)) begin
      errSpurious_d = 1'b1;
    end
  end

  // Outputs decoded from the current state; the accept pulse is combinational
  // so it lands in the same cycle the operands are latched.
  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && grantValid) begin
      bus.req_ready[winner] = 1'b1;
    end
    bus.k_ap_start = (state_q == LAUNCH);
    bus.rsp_valid  = (state_q == RESPOND);
    busy           = (state_q != IDLE);
  end

  assign bus.k_rollback    = kRollback_q;
  assign bus.k_ts          = kTs_q;
  assign bus.k_data        = kData_q;
  assign bus.rsp_id        = rspId_q;
  assign bus.rsp_data      = rspData_q;
  assign err_spurious_done = errSpurious_q;

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] cntBusy_q, cntGrantEv_q, cntGrantRb_q, cntStallRsp_q;

  // Saturating performance counters.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cntBusy_q     <= '0;
      cntGrantEv_q  <= '0;
      cntGrantRb_q  <= '0;
      cntStallRsp_q <= '0;
    end else begin
      if (busy && cntBusy_q != 32'hFFFF_FFFF) begin
        cntBusy_q <= cntBusy_q + 32'd1;
      end
      if (state_q == IDLE && grantValid && !grantRb && cntGrantEv_q != 32'hFFFF_FFFF) begin
        cntGrantEv_q <= cntGrantEv_q + 32'd1;
      end
      if (state_q == IDLE && grantValid && grantRb && cntGrantRb_q != 32'hFFFF_FFFF) begin
        cntGrantRb_q <= cntGrantRb_q + 32'd1;
      end
      if (state_q == RESPOND && !bus.rsp_ready && cntStallRsp_q != 32'hFFFF_FFFF) begin
        cntStallRsp_q <= cntStallRsp_q + 32'd1;
      end
    end
  end

  assign cnt_busy      = cntBusy_q;
  assign cnt_grant_ev  = cntGrantEv_q;
  assign cnt_grant_rb  = cntGrantRb_q;
  assign cnt_stall_rsp = cntStallRsp_q;
`endif

endmodule

// File: tb/tb_event_kernel_scheduler.sv
// Self-checking bench for event_kernel_scheduler. A behavioural model keeps
// one round-robin pointer per class and picks winners by plain modular search;
// the bench plays the kernel and the response consumer.
module tb_event_kernel_scheduler;
  localparam int N_REQ  = 4;
  localparam int TS_W   = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 2;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  logic busy;
  logic err_spurious_done;

  event_kernel_scheduler_if #(.N_REQ(N_REQ), .TS_W(TS_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus();

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] cnt_busy, cnt_grant_ev, cnt_grant_rb, cnt_stall_rsp;
`endif

  event_kernel_scheduler #(.N_REQ(N_REQ), .TS_W(TS_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .ap_clk            (ap_clk),
    .ap_rst_n          (ap_rst_n),
    .bus               (bus),
    .busy              (busy),
    .err_spurious_done (err_spurious_done)
`ifdef SCHED_PERF_CNT_EN
    ,
    .cnt_busy          (cnt_busy),
    .cnt_grant_ev      (cnt_grant_ev),
    .cnt_grant_rb      (cnt_grant_rb),
    .cnt_stall_rsp     (cnt_stall_rsp)
`endif
  );

  // Free-running clock.
  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int mRbPtr;
  int mEvPtr;
  logic [TS_W-1:0]   tsArr   [N_REQ];
  logic [DATA_W-1:0] dataArr [N_REQ];

  // Observations from the last transaction
  bit                oGranted;
  logic [N_REQ-1:0]  oGrant;
  int                oWin;
  logic              oKRb;
  logic [TS_W-1:0]   oKTs;
  logic [DATA_W-1:0] oKData;
  bit                oOpsStable;
  int                oStartCycles;
  bit                oReadyLeak;
  bit                oRspValidAll;
  bit                oRspStable;
  logic [ID_W-1:0]   oRspId;
  logic [DATA_W-1:0] oRspData;

  // Winner by the arbitration rule: rollbacks first, then inserts, each from its pointer.
  function automatic int modelPick(input logic [N_REQ-1:0] v, input logic [N_REQ-1:0] rb,
                                   input int rbp, input int evp, output bit isRb);
    isRb = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (v[(rbp + k) % N_REQ] && rb[(rbp + k) % N_REQ]) begin
        isRb = 1'b1;
        return (rbp + k) % N_REQ;
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (v[(evp + k) % N_REQ] && !rb[(evp + k) % N_REQ]) return (evp + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic modelCommit(input int w, input bit isRb);
    if (isRb) mRbPtr = (w + 1) % N_REQ;
    else      mEvPtr = (w + 1) % N_REQ;
  endtask

  task automatic driveReq(input logic [N_REQ-1:0] v, input logic [N_REQ-1:0] rb);
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_ts[i*TS_W +: TS_W]       = tsArr[i];
      bus.req_data[i*DATA_W +: DATA_W] = dataArr[i];
    end
    bus.req_rollback = rb;
    bus.req_valid    = v;
  endtask

  task automatic applyReset();
    ap_rst_n = 1'b0;
    driveReq('0, '0);
    bus.k_ap_ready = 1'b0;
    bus.k_ap_done  = 1'b0;
    bus.k_return   = '0;
    bus.rsp_ready  = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    mRbPtr = 0;
    mEvPtr = 0;
    @(posedge ap_clk); #1;
  endtask

  // Plays one transaction from IDLE (requests already driven): kernel ready after
  // readyLat cycles, done doneLat cycles after ready, response stalled rspStall cycles.
  task automatic runTxn(input int readyLat, input int doneLat, input int rspStall,
                        input logic [DATA_W-1:0] retVal, input bit dropWinner);
    oGranted = 0; oWin = -1; oOpsStable = 1; oStartCycles = 0; oReadyLeak = 0;
    oRspValidAll = 1; oRspStable = 1;
    #1;
    oGrant = bus.req_ready;
    for (int i = 0; i < N_REQ; i++) if (oGrant[i]) oWin = i;
    if (oGrant == '0) return;
    oGranted = 1;
    @(posedge ap_clk); #1;
    if (dropWinner) bus.req_valid[oWin] = 1'b0;
    for (int c = 0; c <= readyLat; c++) begin
      if (c == readyLat) begin
        bus.k_ap_ready = 1'b1;
        if (doneLat == 0) begin bus.k_ap_done = 1'b1; bus.k_return = retVal; end
      end
      #1;
      if (c == 0) begin oKRb = bus.k_rollback; oKTs = bus.k_ts; oKData = bus.k_data; end
      else if (bus.k_rollback !== oKRb || bus.k_ts !== oKTs || bus.k_data !== oKData) oOpsStable = 0;
      if (bus.k_ap_start === 1'b1) oStartCycles++;
      if (bus.req_ready !== '0) oReadyLeak = 1;
      @(posedge ap_clk); #1;
    end
    bus.k_ap_ready = 1'b0;
    bus.k_ap_done  = 1'b0;
    bus.k_return   = ~retVal;
    for (int c = 1; c <= doneLat; c++) begin
      if (c == doneLat) begin bus.k_ap_done = 1'b1; bus.k_return = retVal; end
      else bus.k_return = $urandom;
      #1;
      if (bus.k_ap_start === 1'b1) oStartCycles++;
      if (bus.k_ts !== oKTs || bus.k_data !== oKData) oOpsStable = 0;
      if (bus.req_ready !== '0) oReadyLeak = 1;
      @(posedge ap_clk); #1;
    end
    bus.k_ap_done = 1'b0;
    bus.k_return  = $urandom;
    for (int c = 0; c <= rspStall; c++) begin
      bus.rsp_ready = (c == rspStall);
      #1;
      if (bus.rsp_valid !== 1'b1) oRspValidAll = 0;
      if (c == 0) begin oRspId = bus.rsp_id; oRspData = bus.rsp_data; end
      else if (bus.rsp_id !== oRspId || bus.rsp_data !== oRspData) oRspStable = 0;
      if (bus.k_ap_start === 1'b1) oStartCycles++;
      if (bus.req_ready !== '0) oReadyLeak = 1;
      @(posedge ap_clk); #1;
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    driveReq('0, '0);
    bus.k_ap_ready = 1'b0; bus.k_ap_done = 1'b0; bus.k_return = '0; bus.rsp_ready = 1'b0;
    @(posedge ap_clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (err_spurious_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%0b exp=0", err_spurious_done); end
    checks++; if (bus.k_ap_start !== 1'b0) begin failures++; $display("[TB] FAIL reset_start got=%0b exp=0", bus.k_ap_start); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got=%0b exp=0", bus.rsp_valid); end
    checks++; if (bus.req_ready !== '0) begin failures++; $display("[TB] FAIL reset_req_ready got=%b exp=0", bus.req_ready); end
    checks++; if (bus.k_ts !== '0 || bus.k_data !== '0 || bus.k_rollback !== 1'b0) begin failures++; $display("[TB] FAIL reset_operands got ts=%h data=%h rb=%b exp=0", bus.k_ts, bus.k_data, bus.k_rollback); end
    checks++; if (bus.rsp_id !== '0 || bus.rsp_data !== '0) begin failures++; $display("[TB] FAIL reset_rsp got id=%0d data=%h exp=0", bus.rsp_id, bus.rsp_data); end
    applyReset();
  endtask

  task automatic test_single();
    int exp; bit isRb;
    tsArr[1] = 32'h10; dataArr[1] = 32'hAB;
    driveReq(4'b0010, 4'b0000);
    exp = modelPick(4'b0010, 4'b0000, mRbPtr, mEvPtr, isRb);
    runTxn(2, 0, 0, 32'h55, 1);
    modelCommit(exp, isRb);
    checks++; if (oGrant !== 4'b0010) begin failures++; $display("[TB] FAIL single_grant got=%b exp=0010", oGrant); end
    checks++; if (oKTs !== 32'h10 || oKData !== 32'hAB || oKRb !== 1'b0) begin failures++; $display("[TB] FAIL single_operands got ts=%h data=%h rb=%b exp ts=10 data=ab rb=0", oKTs, oKData, oKRb); end
    checks++; if (oOpsStable !== 1'b1) begin failures++; $display("[TB] FAIL single_ops_stable got=%0b exp=1", oOpsStable); end
    checks++; if (oStartCycles != 3) begin failures++; $display("[TB] FAIL single_start_cycles got=%0d exp=3", oStartCycles); end
    checks++; if (oRspId !== 2'd1 || oRspData !== 32'h55) begin failures++; $display("[TB] FAIL single_rsp got id=%0d data=%h exp id=1 data=55", oRspId, oRspData); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_idle_after got busy=%0b exp=0", busy); end
  endtask

  task automatic test_priority();
    int exp; bit isRb;
    for (int i = 0; i < N_REQ; i++) begin tsArr[i] = $urandom; dataArr[i] = $urandom; end
    driveReq(4'b1001, 4'b1000);
    exp = modelPick(4'b1001, 4'b1000, mRbPtr, mEvPtr, isRb);
    runTxn(1, 1, 0, 32'hCAFE_0003, 1);
    modelCommit(exp, isRb);
    checks++; if (oGrant !== 4'b1000 || exp != 3) begin failures++; $display("[TB] FAIL prio_first_grant got=%b exp=1000", oGrant); end
    checks++; if (oKRb !== 1'b1 || oKTs !== tsArr[3]) begin failures++; $display("[TB] FAIL prio_first_ops got rb=%b ts=%h exp rb=1 ts=%h", oKRb, oKTs, tsArr[3]); end
    checks++; if (oReadyLeak !== 1'b0) begin failures++; $display("[TB] FAIL prio_no_early_grant got leak=%0b exp=0", oReadyLeak); end
    checks++; if (oRspId !== 2'd3 || oRspData !== 32'hCAFE_0003) begin failures++; $display("[TB] FAIL prio_first_rsp got id=%0d data=%h exp id=3 data=cafe0003", oRspId, oRspData); end
    exp = modelPick(4'b0001, 4'b0000, mRbPtr, mEvPtr, isRb);
    runTxn(0, 2, 0, 32'hCAFE_0000, 1);
    modelCommit(exp, isRb);
    checks++; if (oGrant !== 4'b0001 || oKRb !== 1'b0) begin failures++; $display("[TB] FAIL prio_second_grant got=%b rb=%b exp=0001 rb=0", oGrant, oKRb); end
    checks++; if (oRspId !== 2'd0 || oRspData !== 32'hCAFE_0000) begin failures++; $display("[TB] FAIL prio_second_rsp got id=%0d data=%h exp id=0 data=cafe0000", oRspId, oRspData); end
  endtask

  task automatic test_round_robin();
    int exp; bit isRb; logic [DATA_W-1:0] ret;
    applyReset();
    for (int i = 0; i < N_REQ; i++) begin tsArr[i] = $urandom; dataArr[i] = $urandom; end
    driveReq(4'b1111, 4'b0000);
    for (int t = 0; t < 4; t++) begin
      exp = modelPick(4'b1111, 4'b0000, mRbPtr, mEvPtr, isRb);
      ret = $urandom;
      runTxn($urandom_range(0, 2), $urandom_range(0, 2), 0, ret, 0);
      modelCommit(exp, isRb);
      checks++; if (oWin != t || exp != t) begin failures++; $display("[TB] FAIL rr_order_%0d got=%0d exp=%0d", t, oWin, t); end
      checks++; if (oRspId !== ID_W'(t) || oRspData !== ret || oKData !== dataArr[t]) begin failures++; $display("[TB] FAIL rr_rsp_%0d got id=%0d data=%h kdata=%h exp id=%0d data=%h kdata=%h", t, oRspId, oRspData, oKData, t, ret, dataArr[t]); end
    end
    driveReq(4'b0101, 4'b0101);
    exp = modelPick(4'b0101, 4'b0101, mRbPtr, mEvPtr, isRb);
    runTxn(0, 0, 0, 32'h1234, 1);
    modelCommit(exp, isRb);
    checks++; if (oGrant !== 4'b0001 || oKRb !== 1'b1) begin failures++; $display("[TB] FAIL rr_rb_ptr_unchanged got=%b rb=%b exp=0001 rb=1", oGrant, oKRb); end
    driveReq('0, '0);
  endtask

  task automatic test_backpressure();
    int exp; bit isRb; logic [DATA_W-1:0] ret;
    for (int i = 0; i < N_REQ; i++) begin tsArr[i] = $urandom; dataArr[i] = $urandom; end
    driveReq(4'b0110, 4'b0000);
    exp = modelPick(4'b0110, 4'b0000, mRbPtr, mEvPtr, isRb);
    ret = $urandom;
    runTxn(0, 2, 5, ret, 1);
    modelCommit(exp, isRb);
    checks++; if (oWin != exp) begin failures++; $display("[TB] FAIL bp_grant got=%0d exp=%0d", oWin, exp); end
    checks++; if (oRspValidAll !== 1'b1 || oRspStable !== 1'b1) begin failures++; $display("[TB] FAIL bp_rsp_stable got valid_all=%0b stable=%0b exp=1 1", oRspValidAll, oRspStable); end
    checks++; if (oReadyLeak !== 1'b0) begin failures++; $display("[TB] FAIL bp_no_grant_while_busy got leak=%0b exp=0", oReadyLeak); end
    checks++; if (oRspId !== ID_W'(exp) || oRspData !== ret) begin failures++; $display("[TB] FAIL bp_rsp got id=%0d data=%h exp id=%0d data=%h", oRspId, oRspData, exp, ret); end
    exp = modelPick(bus.req_valid, 4'b0000, mRbPtr, mEvPtr, isRb);
    runTxn(0, 0, 0, 32'h77, 1);
    modelCommit(exp, isRb);
    checks++; if (oGranted !== 1'b1 || oWin != exp) begin failures++; $display("[TB] FAIL bp_next_grant got=%0d exp=%0d", oWin, exp); end
  endtask

  task automatic test_same_cycle();
    int exp; bit isRb; logic [N_REQ-1:0] v;
    v = '0; v[$urandom_range(0, N_REQ - 1)] = 1'b1;
    tsArr[0] = $urandom; dataArr[0] = $urandom;
    driveReq(v, 4'b0000);
    exp = modelPick(v, 4'b0000, mRbPtr, mEvPtr, isRb);
    runTxn(0, 0, 0, 32'h5A5A_A5A5, 1);
    modelCommit(exp, isRb);
    checks++; if (oStartCycles != 1) begin failures++; $display("[TB] FAIL same_cycle_start_len got=%0d exp=1", oStartCycles); end
    checks++; if (oRspValidAll !== 1'b1) begin failures++; $display("[TB] FAIL same_cycle_rsp_next got=%0b exp=1", oRspValidAll); end
    checks++; if (oWin != exp || oRspData !== 32'h5A5A_A5A5) begin failures++; $display("[TB] FAIL same_cycle_rsp got win=%0d data=%h exp win=%0d data=5a5aa5a5", oWin, oRspData, exp); end
  endtask

  task automatic test_random();
    int exp; bit isRb; logic [N_REQ-1:0] v, rb; logic [DATA_W-1:0] ret;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N_REQ; i++) begin tsArr[i] = $urandom; dataArr[i] = $urandom; end
      v = N_REQ'($urandom_range(1, 15)); rb = N_REQ'($urandom);
      driveReq(v, rb);
      exp = modelPick(v, rb, mRbPtr, mEvPtr, isRb);
      ret = $urandom;
      runTxn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), ret, 1);
      checks++; if (oGranted !== 1'b1 || oWin != exp) begin failures++; $display("[TB] FAIL rand_grant_%0d got=%0d exp=%0d", t, oWin, exp); end
      if (oGranted) begin
        modelCommit(exp, isRb);
        checks++; if (oKRb !== isRb || oKTs !== tsArr[exp] || oKData !== dataArr[exp]) begin failures++; $display("[TB] FAIL rand_ops_%0d got rb=%b ts=%h data=%h exp rb=%b ts=%h data=%h", t, oKRb, oKTs, oKData, isRb, tsArr[exp], dataArr[exp]); end
        checks++; if (oOpsStable !== 1'b1 || oReadyLeak !== 1'b0) begin failures++; $display("[TB] FAIL rand_hold_%0d got stable=%0b leak=%0b exp=1 0", t, oOpsStable, oReadyLeak); end
        checks++; if (oRspId !== ID_W'(exp) || oRspData !== ret || oRspStable !== 1'b1) begin failures++; $display("[TB] FAIL rand_rsp_%0d got id=%0d data=%h exp id=%0d data=%h", t, oRspId, oRspData, exp, ret); end
      end
    end
    driveReq('0, '0);
  endtask

  task automatic test_spurious_reset();
    driveReq('0, '0);
    bus.k_ap_done = 1'b1;
    @(posedge ap_clk); #1;
    bus.k_ap_done = 1'b0;
    checks++; if (err_spurious_done !== 1'b1) begin failures++; $display("[TB] FAIL spurious_set got=%0b exp=1", err_spurious_done); end
    @(posedge ap_clk); #1;
    checks++; if (err_spurious_done !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL spurious_sticky got err=%0b busy=%0b exp=1 0", err_spurious_done, busy); end
    driveReq(4'b0001, 4'b0000);
    @(posedge ap_clk); #1;
    driveReq('0, '0);
    checks++; if (bus.k_ap_start !== 1'b1 || busy !== 1'b1) begin failures++; $display("[TB] FAIL launch_before_reset got start=%0b busy=%0b exp=1 1", bus.k_ap_start, busy); end
    ap_rst_n = 1'b0;
    #1;
    checks++; if (bus.k_ap_start !== 1'b0 || bus.rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_start got start=%0b rsp_valid=%0b exp=0 0", bus.k_ap_start, bus.rsp_valid); end
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    mRbPtr = 0; mEvPtr = 0;
    @(posedge ap_clk); #1;
    checks++; if (busy !== 1'b0 || err_spurious_done !== 1'b0 || bus.k_ap_start !== 1'b0) begin failures++; $display("[TB] FAIL after_reset got busy=%0b err=%0b start=%0b exp=0 0 0", busy, err_spurious_done, bus.k_ap_start); end
  endtask

  // Safety net so a wedged run still ends with a verdict.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  // Test sequence.
  initial begin
    for (int i = 0; i < N_REQ; i++) begin tsArr[i] = '0; dataArr[i] = '0; end
    mRbPtr = 0; mEvPtr = 0;
    test_reset();
    test_single();
    test_priority();
    test_round_robin();
    test_backpressure();
    test_same_cycle();
    test_random();
    test_spurious_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
